// File: rtl/contador_gray_param.sv
`default_nettype none
// ============================================================================
// Module   : contador_gray_param
// Brief    : Up/down Gray-code counter with parallel load, wrap/saturate
//            limits, a binary mirror output and a terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module contador_gray_param #(
  parameter int WIDTH    = 5,
  parameter int MODO_SAT = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] dato_load,
  output logic [WIDTH-1:0] salida_gray,
  output logic [WIDTH-1:0] salida_bin,
  output logic             fin_cuenta
);

  localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               C_SAT  = (MODO_SAT != 0);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_fin;

  logic             w_at_limit;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_at_limit = up_down ? (r_bin == C_MAX) : (r_bin == C_ZERO);
    w_next     = r_bin;
    if (load) begin
      w_next = dato_load;
    end else if (enable) begin
      // Plain modulo arithmetic already yields the wrap; saturation only blocks it.
      if (!(w_at_limit && C_SAT)) begin
        w_next = up_down ? (r_bin + C_ONE) : (r_bin - C_ONE);
      end
    end
  end

  // Gray is encoded from the next binary value so both outputs update together.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_bin  <= C_ZERO;
      r_gray <= C_ZERO;
      r_fin  <= 1'b0;
    end else begin
      r_bin  <= w_next;
      r_gray <= w_next ^ (w_next >> 1);
      r_fin  <= !load && enable && w_at_limit;
    end
  end

  assign salida_bin  = r_bin;
  assign salida_gray = r_gray;
  assign fin_cuenta  = r_fin;

endmodule
`default_nettype wire

// File: tb/tb_contador_gray_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_gray_param
// Brief    : Checks wrap and saturate counters side by side against an
//            arithmetic reference model under directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_gray_param;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_L;
  logic         enable;
  logic         up_down;
  logic         load;
  logic [W-1:0] dato_load;

  logic [W-1:0] gray_o [2];
  logic [W-1:0] bin_o  [2];
  logic         fin_o  [2];

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 wraps, index 1 saturates.
  int m_b   [2];
  int m_fin [2];
  logic [W-1:0] prev_gray [2];

  always #5 clk = ~clk;

  contador_gray_param #(.WIDTH(W), .MODO_SAT(0)) u_wrap (
    .clk(clk), .reset_L(reset_L), .enable(enable), .up_down(up_down),
    .load(load), .dato_load(dato_load),
    .salida_gray(gray_o[0]), .salida_bin(bin_o[0]), .fin_cuenta(fin_o[0])
  );

  contador_gray_param #(.WIDTH(W), .MODO_SAT(1)) u_sat (
    .clk(clk), .reset_L(reset_L), .enable(enable), .up_down(up_down),
    .load(load), .dato_load(dato_load),
    .salida_gray(gray_o[1]), .salida_bin(bin_o[1]), .fin_cuenta(fin_o[1])
  );

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s[%0d].gray", tag, k), 32'(gray_o[k]), 32'(gray_of(m_b[k])));
      chk($sformatf("%s[%0d].bin", tag, k), 32'(bin_o[k]), 32'(m_b[k]));
      chk($sformatf("%s[%0d].fin", tag, k), 32'(fin_o[k]), 32'(m_fin[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_b[k]       = 0;
      m_fin[k]     = 0;
      prev_gray[k] = '0;
    end
  endtask

  // One clock edge: apply inputs, step the model, compare after the edge.
  task automatic tick(input string tag, input logic en, input logic ud,
                      input logic ld, input logic [W-1:0] d);
    int old_b [2];
    enable    = en;
    up_down   = ud;
    load      = ld;
    dato_load = d;
    for (int k = 0; k < 2; k++) begin
      old_b[k]     = m_b[k];
      prev_gray[k] = gray_o[k];
      if (ld) begin
        m_b[k]   = int'(d);
        m_fin[k] = 0;
      end else if (en) begin
        if (ud) begin
          m_fin[k] = (m_b[k] == MAX) ? 1 : 0;
          if (m_b[k] == MAX) m_b[k] = (k == 1) ? MAX : 0;
          else               m_b[k] = m_b[k] + 1;
        end else begin
          m_fin[k] = (m_b[k] == 0) ? 1 : 0;
          if (m_b[k] == 0) m_b[k] = (k == 1) ? 0 : MAX;
          else             m_b[k] = m_b[k] - 1;
        end
      end else begin
        m_fin[k] = 0;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
    if (!ld && en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s[%0d].bits_changed", tag, k),
            32'($countones(prev_gray[k] ^ gray_o[k])),
            (old_b[k] != m_b[k]) ? 32'd1 : 32'd0);
      end
    end
  endtask

  initial begin
    reset_L   = 1'b0;
    enable    = 1'b0;
    up_down   = 1'b0;
    load      = 1'b0;
    dato_load = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_L = 1'b1;

    // Up count through the whole range, then wrap.
    for (int i = 0; i < 31; i++) tick("up", 1'b1, 1'b1, 1'b0, '0);
    chk("up_end.gray", 32'(gray_o[0]), 32'h10);
    chk("up_end.bin",  32'(bin_o[0]),  32'h1f);
    tick("wrap_up", 1'b1, 1'b1, 1'b0, '0);
    chk("wrap_up.gray0", 32'(gray_o[0]), 32'h00);
    tick("wrap_up_next", 1'b1, 1'b1, 1'b0, '0);
    chk("wrap_up_next.gray1", 32'(gray_o[0]), 32'h01);

    // Down wrap from reset.
    #2 reset_L = 1'b0;
    #1 model_reset();
    #1 reset_L = 1'b1;
    tick("wrap_dn1", 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_dn1.gray", 32'(gray_o[0]), 32'h10);
    tick("wrap_dn2", 1'b1, 1'b0, 1'b0, '0);
    chk("wrap_dn2.gray", 32'(gray_o[0]), 32'h11);

    // Load overrides enable, then holds.
    tick("load", 1'b1, 1'b1, 1'b1, 5'b01010);
    chk("load.gray", 32'(gray_o[0]), 32'h0f);
    for (int i = 0; i < 5; i++) tick("hold", 1'b0, 1'b1, 1'b0, '0);

    // Saturation against the top, then step back down.
    tick("load_max", 1'b0, 1'b0, 1'b1, 5'b11111);
    for (int i = 0; i < 3; i++) tick("sat_up", 1'b1, 1'b1, 1'b0, '0);
    chk("sat_up.gray", 32'(gray_o[1]), 32'h10);
    tick("sat_dn", 1'b1, 1'b0, 1'b0, '0);
    chk("sat_dn.bin", 32'(bin_o[1]), 32'h1e);

    // Saturation against zero.
    tick("load_zero", 1'b0, 1'b0, 1'b1, 5'b00000);
    for (int i = 0; i < 2; i++) tick("sat_dn0", 1'b1, 1'b0, 1'b0, '0);

    // Asynchronous reset between edges, with a pending load.
    tick("load_13", 1'b0, 1'b0, 1'b1, 5'b01101);
    load      = 1'b1;
    dato_load = 5'b10101;
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    load = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_with_load");
    reset_L = 1'b1;
    tick("after_rst", 1'b1, 1'b1, 1'b0, '0);
    chk("after_rst.gray", 32'(gray_o[0]), 32'h01);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/contador_gray_param.md
Name: contador_gray_param

Overview:
Parametrised Gray-code counter. It is the successor to the fixed 5-bit up-only Gray counter.
- Adds configurable width, up/down direction and synchronous parallel load.
- Adds a selectable wrap or saturate mode at the limits.
- Adds a binary mirror output and a terminal-count pulse.
- Sits beside the existing counters and is driven by the same tester-style benches: clk, reset_L and enable come from a tester module, and outputs are compared against a synthesised netlist.

Parameters:
- WIDTH, 5, counter width in bits (legal range 2..16).
- MODO_SAT, 0, 0 = wrap at limits, 1 = saturate (hold) at limits.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous active-low reset.
- enable  input  1  count enable, sampled on the clk rising edge.
- up_down  input  1  1 = count up, 0 = count down; sampled with enable.
- load  input  1  synchronous load request.
- dato_load  input  WIDTH  binary value to load.
- salida_gray  output  WIDTH  registered Gray-code count.
- salida_bin  output  WIDTH  registered binary count, always equal to the Gray decode of salida_gray.
- fin_cuenta  output  1  registered terminal-count pulse.

Behaviour:
- Reset:
  - reset_L=0 asynchronously forces salida_gray=0, salida_bin=0, fin_cuenta=0, without waiting for clk.
  - The first count is taken on the first rising edge after reset_L rises.
- Internal state: one WIDTH-bit binary register b.
  - salida_bin = b.
  - salida_gray = b ^ (b >> 1), registered in the same edge as b.
  - No combinational path exists from any input to any output.
- Priority at each rising edge: load > enable > hold.
- Load (load=1): b <= dato_load, regardless of enable and up_down; fin_cuenta <= 0. Loading does not need to obey the one-bit-change rule.
- Count up (enable=1, load=0, up_down=1):
  - If b < 2^WIDTH-1: b <= b+1.
  - If b == 2^WIDTH-1 and MODO_SAT=0: b <= 0.
  - If b == 2^WIDTH-1 and MODO_SAT=1: b holds.
- Count down (enable=1, load=0, up_down=0):
  - If b > 0: b <= b-1.
  - If b == 0 and MODO_SAT=0: b <= 2^WIDTH-1.
  - If b == 0 and MODO_SAT=1: b holds.
- Hold (enable=0, load=0): b holds and fin_cuenta <= 0.
- fin_cuenta:
  - Goes to 1 for the cycle after an edge where enable=1, load=0 and b was at the terminal value for the current direction (max for up, 0 for down). Otherwise it goes to 0.
  - Saturate mode: fin_cuenta stays high every cycle while enabled counting continues against the limit.
  - Wrap mode: it is a single-cycle pulse per wrap.
- Gray property: every enabled count step, including wrap, changes exactly one bit of salida_gray. A saturating hold changes zero bits.
- Direction change mid-count takes effect on the same edge it is sampled; there is no pipeline penalty.
- reset_L asserted mid-count overrides everything immediately. A load and a reset in the same cycle resolve to reset.
- Arithmetic is modulo 2^WIDTH on b only. No carries propagate outside the counter.

Test Plan (WIDTH=5 unless noted):
1. Reset then up count: hold reset_L=0 for 2 cycles -> outputs 00000 and fin_cuenta=0. Then enable=1, up_down=1 for 31 edges:
   - salida_gray steps 00000, 00001, 00011, 00010, 00110 ... and ends at 10000 with salida_bin=11111.
   - Each step changes exactly 1 bit.
2. Wrap up: from the end state of scenario 1, one more edge -> salida_gray=00000 and fin_cuenta=1 for exactly one cycle. The next edge gives 00001 with fin_cuenta=0.
3. Wrap down: from reset, enable=1, up_down=0 -> first edge gives salida_gray=10000, salida_bin=11111, fin_cuenta=1. The second edge gives salida_gray=10001, salida_bin=11110.
4. Load priority: load=1, dato_load=01010, enable=1 -> salida_bin=01010, salida_gray=01111, fin_cuenta=0. With enable=0 afterwards, the value holds for 5 cycles.
5. Saturate (MODO_SAT=1): load 11111, then 3 up edges -> salida_gray stays 10000 and fin_cuenta=1 on all 3 cycles. A down edge then gives salida_bin=11110 and fin_cuenta=0.
6. Async reset mid-count: drop reset_L between clock edges while the count is at 01101 -> outputs read 00000 before the next rising edge. Release reset_L, then count up 1 -> salida_gray=00001.
